diff_alert_tx: RTL and testbench



---
 rtl/diff_alert_pkg.sv | 16 +
 rtl/diff_ack_rx.sv | 65 ++++++
 rtl/diff_alert_tx.sv | 124 ++++++++++++
 tb/tb_diff_alert_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_alert_pkg.sv
// Shared types and encodings for the differential alert transmitter.
// The alert pair encodings are written {p, n}.
package diff_alert_pkg;

  typedef enum logic [2:0] {Idle, Phase1, Phase2, Pause0, Pause1} alert_tx_state_e;

  localparam bit [1:0] ALERT_IDLE   = 2'b01;
  localparam bit [1:0] ALERT_ASSERT = 2'b10;
  localparam bit [1:0] ALERT_SIGINT = 2'b11;

  // Width of the timeout counter. It must hold TimeoutCycles itself, and it is at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/diff_ack_rx.sv
// Ack pair front end. It has optional 2-flop synchronisers, a sigint filter,
// and it holds the last validly encoded ack level.
module diff_ack_rx
  import diff_alert_pkg::*;
#(
  parameter bit AsyncAck = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ack_pi,
  input  logic ack_ni,
  output logic ack_lvl_o,
  output logic sigint_o
);

  logic w_p;
  logic w_n;
  logic w_eq;
  logic w_sigint;
  logic r_lvl;

  assign w_eq = ~(w_p ^ w_n);

  generate
    if (AsyncAck) begin : g_sync
      logic [1:0] r_p_sync;
      logic [1:0] r_n_sync;
      logic       r_eq_q;

      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_p_sync <= 2'b00;
          r_n_sync <= 2'b11;
          r_eq_q   <= 1'b0;
        end else begin
          r_p_sync <= {r_p_sync[0], ack_pi};
          r_n_sync <= {r_n_sync[0], ack_ni};
          r_eq_q   <= w_eq;
        end
      end

      assign w_p = r_p_sync[1];
      assign w_n = r_n_sync[1];
      // A single equal cycle is wire skew. Only a second consecutive equal cycle is an integrity fault.
      assign w_sigint = w_eq & r_eq_q;
    end else begin : g_direct
      assign w_p      = ack_pi;
      assign w_n      = ack_ni;
      assign w_sigint = w_eq;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lvl <= 1'b0;
    end else if (!w_eq) begin
      r_lvl <= w_p;
    end
  end

  assign ack_lvl_o = w_eq ? r_lvl : w_p;
  assign sigint_o  = w_sigint;

endmodule

// File: rtl/diff_alert_tx.sv
// Transmit side of the differential alert link. It runs a four-phase handshake
// on the alert pair and supervises the returning ack pair for timeouts and sigint.
module diff_alert_tx
  import diff_alert_pkg::*;
#(
  parameter bit          AsyncAck      = 1'b0,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic alert_req_i,
  input  logic ack_pi,
  input  logic ack_ni,
  output logic alert_po,
  output logic alert_no,
  output logic done_o,
  output logic busy_o,
  output logic timeout_o,
  output logic sigint_o
);

  localparam int unsigned        CntW   = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0]    CntMax = CntW'(TimeoutCycles);

  alert_tx_state_e r_state;
  alert_tx_state_e w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic [1:0]      r_alert;
  logic [1:0]      w_alert_nxt;
  logic            r_pending;
  logic            r_sigint_q;
  logic            w_ack_lvl;
  logic            w_sigint;
  logic            w_timeout_hit;
  logic            w_launch;
  logic            w_retry;
  logic            w_done;
  logic            w_timeout;

  diff_ack_rx #(.AsyncAck(AsyncAck)) u_ack_rx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ack_pi    (ack_pi),
    .ack_ni    (ack_ni),
    .ack_lvl_o (w_ack_lvl),
    .sigint_o  (w_sigint)
  );

  assign w_timeout_hit = (TimeoutCycles != 0) && (r_cnt == CntMax);

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_alert_nxt = ALERT_IDLE;
    w_launch    = 1'b0;
    w_retry     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;

    case (r_state)
      Idle: begin
        if (r_pending && !w_sigint) begin
          w_state_nxt = Phase1;
          w_launch    = 1'b1;
        end
      end
      Phase1, Phase2: begin
        w_alert_nxt = (r_state == Phase1) ? ALERT_ASSERT : ALERT_IDLE;
        // Priority: sigint holds, then abort after sigint, then ack, then timeout.
        if (w_sigint) begin
          w_alert_nxt = ALERT_SIGINT;
        end else if (r_sigint_q) begin
          w_state_nxt = Pause0;
          w_retry     = 1'b1;
        end else if (r_state == Phase1 && w_ack_lvl) begin
          w_state_nxt = Phase2;
        end else if (r_state == Phase2 && !w_ack_lvl) begin
          w_state_nxt = Pause0;
          w_done      = 1'b1;
        end else if (w_timeout_hit) begin
          w_state_nxt = Pause0;
          w_timeout   = 1'b1;
          w_retry     = 1'b1;
        end else if (r_cnt != CntMax) begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      Pause0:  w_state_nxt = Pause1;
      Pause1:  w_state_nxt = Idle;
      default: w_state_nxt = Idle;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= Idle;
      r_cnt      <= '0;
      r_alert    <= ALERT_IDLE;
      r_pending  <= 1'b0;
      r_sigint_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_alert    <= w_alert_nxt;
      // A request arriving in the same cycle as the launch keeps pending set for a follow-up handshake.
      r_pending  <= alert_req_i | w_retry | (r_pending & ~w_launch);
      r_sigint_q <= w_sigint;
    end
  end

  assign alert_po  = r_alert[1];
  assign alert_no  = r_alert[0];
  assign done_o    = w_done;
  assign timeout_o = w_timeout;
  assign sigint_o  = w_sigint;
  assign busy_o    = (r_state != Idle) | r_pending;

endmodule

// File: tb/tb_diff_alert_tx.sv
// Directed bench for diff_alert_tx. dut0 uses a synchronous ack and an 8-cycle timeout.
// dut1 uses an asynchronous ack and a 64-cycle timeout.
module tb_diff_alert_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic req0 = 1'b0, ack_p0 = 1'b0, ack_n0 = 1'b1;
  logic po0, no0, done0, busy0, to0, sig0;
  logic req1 = 1'b0, ack_p1 = 1'b0, ack_n1 = 1'b1;
  logic po1, no1, done1, busy1, to1, sig1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt0 = 0, to_cnt0 = 0, done_cnt1 = 0;
  int low_run = 0, last_gap = 0;
  bit seen_hi = 1'b0;

  always #5 clk = ~clk;

  diff_alert_tx #(.AsyncAck(1'b0), .TimeoutCycles(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .alert_req_i(req0), .ack_pi(ack_p0), .ack_ni(ack_n0),
    .alert_po(po0), .alert_no(no0), .done_o(done0), .busy_o(busy0),
    .timeout_o(to0), .sigint_o(sig0)
  );

  diff_alert_tx #(.AsyncAck(1'b1), .TimeoutCycles(64)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .alert_req_i(req1), .ack_pi(ack_p1), .ack_ni(ack_n1),
    .alert_po(po1), .alert_no(no1), .done_o(done1), .busy_o(busy1),
    .timeout_o(to1), .sigint_o(sig1)
  );

  // Pulse counters, and the length of the most recent low gap on alert_po of dut0.
  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (to0)   to_cnt0++;
    if (done1) done_cnt1++;
    if (rst) begin
      seen_hi = 1'b0;
      low_run = 0;
    end else if (po0) begin
      if (seen_hi && low_run > 0) last_gap = low_run;
      seen_hi = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic po_of(input int d);
    return (d == 0) ? po0 : po1;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  task automatic wait_po(input int d, input logic val, input int max_cyc, input string tag);
    int n = 0;
    while (po_of(d) !== val && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(po_of(d)), 32'(val));
  endtask

  task automatic wait_idle(input int d, input int max_cyc, input string tag);
    int n = 0;
    while (busy_of(d) !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(busy_of(d)), 0);
  endtask

  // Responds on dut0 with the 3-cycle ack timing. It can pulse a new request during Phase2.
  task automatic run_hs0(input bit req_in_phase2, input string tag);
    wait_po(0, 1'b1, 20, {tag, "_rise"});
    repeat (3) tick();
    ack_p0 = 1'b1; ack_n0 = 1'b0;
    wait_po(0, 1'b0, 20, {tag, "_fall"});
    if (req_in_phase2) req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (2) tick();
    ack_p0 = 1'b0; ack_n0 = 1'b1;
  endtask

  task automatic finish_hs0(input string tag);
    ack_p0 = 1'b1; ack_n0 = 1'b0;
    wait_po(0, 1'b0, 20, {tag, "_fall"});
    ack_p0 = 1'b0; ack_n0 = 1'b1;
    wait_idle(0, 20, {tag, "_idle"});
  endtask

  initial begin
    int d0;
    int t0;
    int d1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_po0", 32'(po0), 0);
    check("rst_no0", 32'(no0), 1);
    check("rst_done0", 32'(done0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_to0", 32'(to0), 0);
    check("rst_sig0", 32'(sig0), 0);
    check("rst_pair1", 32'({po1, no1}), 1);
    check("rst_busy1", 32'(busy1), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic handshake. The request is sampled at edge 0.
    d0 = done_cnt0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    check("b_busy_c0", 32'(busy0), 1);
    check("b_po_c0", 32'(po0), 0);
    tick();
    check("b_po_c1", 32'(po0), 0);
    tick();
    check("b_po_c2", 32'(po0), 1);
    repeat (3) tick();
    ack_p0 = 1'b1; ack_n0 = 1'b0;
    #1;
    check("b_done_c5", 32'(done0), 0);
    tick();
    check("b_po_c6", 32'(po0), 1);
    tick();
    check("b_pair_c7", 32'({po0, no0}), 1);
    repeat (3) tick();
    ack_p0 = 1'b0; ack_n0 = 1'b1;
    #1;
    check("b_done_c10", 32'(done0), 1);
    tick();
    check("b_done_c11", 32'(done0), 0);
    tick();
    check("b_busy_c12", 32'(busy0), 1);
    tick();
    check("b_busy_c13", 32'(busy0), 0);
    check("b_done_count", 32'(done_cnt0 - d0), 1);

    // Back-to-back: a second request arrives during Phase2.
    d0 = done_cnt0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    run_hs0(1'b1, "bb1");
    run_hs0(1'b0, "bb2");
    wait_idle(0, 20, "bb_idle");
    check("bb_done_count", 32'(done_cnt0 - d0), 2);
    check("bb_low_gap", 32'(last_gap), 8);

    // Timeout: ack stays at 0/1. Phase1 is entered at edge 1.
    d0 = done_cnt0;
    t0 = to_cnt0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    repeat (7) tick();
    check("to_c8", 32'(to0), 0);
    tick();
    check("to_c9", 32'(to0), 1);
    check("to_po_c9", 32'(po0), 1);
    tick();
    check("to_c10", 32'(to0), 0);
    tick();
    check("to_po_c11", 32'(po0), 0);
    check("to_busy_c11", 32'(busy0), 1);
    repeat (2) tick();
    check("to_po_c13", 32'(po0), 0);
    tick();
    check("to_retry_c14", 32'(po0), 1);
    check("to_count", 32'(to_cnt0 - t0), 1);
    check("to_no_done", 32'(done_cnt0 - d0), 0);
    finish_hs0("to_fin");

    // Sigint during Phase1. The ack is forced to 1/1 for cycles 2 to 6.
    d0 = done_cnt0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    check("si_pair_c2", 32'({po0, no0}), 2);
    ack_p0 = 1'b1; ack_n0 = 1'b1;
    #1;
    for (int k = 2; k <= 6; k++) begin
      check($sformatf("si_sig_c%0d", k), 32'(sig0), 1);
      if (k >= 3) check($sformatf("si_pair_c%0d", k), 32'({po0, no0}), 3);
      tick();
    end
    check("si_pair_c7", 32'({po0, no0}), 3);
    ack_p0 = 1'b0; ack_n0 = 1'b1;
    #1;
    check("si_sig_c7", 32'(sig0), 0);
    tick();
    check("si_pair_c8", 32'({po0, no0}), 2);
    tick();
    check("si_pair_c9", 32'({po0, no0}), 1);
    repeat (2) tick();
    check("si_po_c11", 32'(po0), 0);
    tick();
    check("si_retry_c12", 32'(po0), 1);
    check("si_no_done", 32'(done_cnt0 - d0), 0);
    finish_hs0("si_fin");

    // Asynchronous ack with one cycle of skew on each ack transition.
    d1 = done_cnt1;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    wait_po(1, 1'b1, 10, "as_rise");
    repeat (2) tick();
    ack_p1 = 1'b1;
    tick();
    check("as_skew_up", 32'(sig1), 0);
    ack_n1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("as_up_%0d", i), 32'(sig1), 0);
    end
    wait_po(1, 1'b0, 20, "as_fall");
    ack_n1 = 1'b1;
    tick();
    check("as_skew_dn", 32'(sig1), 0);
    ack_p1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("as_dn_%0d", i), 32'(sig1), 0);
    end
    wait_idle(1, 20, "as_idle");
    check("as_done_count", 32'(done_cnt1 - d1), 1);

    // Async ack pair held at 1/1 for three samples while idle.
    ack_p1 = 1'b1;
    repeat (2) tick();
    check("as_si_k2", 32'(sig1), 0);
    tick();
    check("as_si_k3", 32'(sig1), 1);
    ack_p1 = 1'b0;
    tick();
    check("as_si_k4", 32'(sig1), 1);
    check("as_si_pair", 32'({po1, no1}), 1);
    tick();
    check("as_si_k5", 32'(sig1), 0);
    check("as_si_busy", 32'(busy1), 0);

    // Reset asserted in the middle of Phase2.
    d0 = done_cnt0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_po(0, 1'b1, 10, "rs_rise");
    ack_p0 = 1'b1; ack_n0 = 1'b0;
    wait_po(0, 1'b0, 20, "rs_fall");
    req0 = 1'b1;
    rst = 1'b1;
    #1;
    req0 = 1'b0;
    check("rs_pair", 32'({po0, no0}), 1);
    check("rs_busy", 32'(busy0), 0);
    check("rs_done", 32'(done0), 0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rs_busy_after_%0d", i), 32'(busy0), 0);
    end
    ack_p0 = 1'b0; ack_n0 = 1'b1;
    tick();
    check("rs_no_done", 32'(done_cnt0 - d0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
